// File: rtl/fu_alloc_ctrl_pkg.sv
// Shared encodings for the issue-stage functional-unit allocator.
// Both dispatch and issue import this so FU indices and kind masks agree.
// Holds the FU kind enum, FU index type and default unit masks.
package fu_alloc_ctrl_pkg;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_LSU = 1'b1
  } fu_kind_e;

  typedef logic [1:0] fu_idx_t;

  localparam int           NUM_FU_C   = 3;
  localparam int           NUM_REQ_C  = 2;
  localparam logic [2:0]   ALU_MASK_C = 3'b011;
  localparam logic [2:0]   LSU_MASK_C = 3'b100;
  localparam int           TIMEOUT_C  = 16;

  localparam int           CNT_W      = 8;
  localparam logic [7:0]   CNT_MAX    = 8'hFF;

endpackage

// File: rtl/fu_pick.sv
// Picks one FU for a single dispatch slot from the currently available set.
// Purely combinational, zero latency.
// No backpressure: pick_vld_o low simply means no eligible unit is free.
module fu_pick
  import fu_alloc_ctrl_pkg::*;
#(
  parameter int                NUM_FU   = NUM_FU_C,
  parameter logic [NUM_FU-1:0] ALU_MASK = ALU_MASK_C
) (
  input  logic [NUM_FU-1:0] avail_i,
  input  logic [NUM_FU-1:0] kind_mask_i,
  input  logic              rr_ptr_i,
  output logic              pick_vld_o,
  output fu_idx_t           pick_idx_o
);

  logic [NUM_FU-1:0] cand;
  logic              rr_mode;
  fu_idx_t           lo_idx;
  fu_idx_t           hi_idx;

  assign cand = avail_i & kind_mask_i;

  // Round-robin only matters when both ALUs are free; otherwise take what is left.
  assign rr_mode = (kind_mask_i == ALU_MASK) && ((cand & ALU_MASK) == ALU_MASK);

  // Lowest and highest eligible index; descending scan leaves the lowest in lo_idx.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (cand[i]) lo_idx = fu_idx_t'(i);
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (cand[i]) hi_idx = fu_idx_t'(i);
    end
  end

  assign pick_vld_o = |cand;
  assign pick_idx_o = (rr_mode && rr_ptr_i) ? hi_idx : lo_idx;

endmodule

// File: rtl/fu_alloc_ctrl.sv
// Allocates ALU/LSU functional units to in-order dispatch slots, tracks busy state and watchdogs.
// Grants are combinational from requests and releases; busy/counters update on the next edge.
// A slot that cannot be granted stalls itself and every younger slot behind it.
module fu_alloc_ctrl
  import fu_alloc_ctrl_pkg::*;
#(
  parameter int                NUM_FU   = NUM_FU_C,
  parameter int                NUM_REQ  = NUM_REQ_C,
  parameter logic [NUM_FU-1:0] ALU_MASK = ALU_MASK_C,
  parameter logic [NUM_FU-1:0] LSU_MASK = LSU_MASK_C,
  parameter int                TIMEOUT  = TIMEOUT_C
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_kind,
  input  logic [NUM_FU-1:0]              i_release,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic [NUM_REQ-1:0][1:0]        o_grant_fu,
  output logic                           o_stall,
  output logic [NUM_FU-1:0]              o_fu_free,
  output logic [NUM_FU-1:0]              o_timeout,
  output logic [NUM_FU-1:0][CNT_W-1:0]   o_busy_cnt
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT - 1);

  logic [NUM_FU-1:0]             busy_q, busy_d;
  logic [NUM_FU-1:0]             to_q, to_d;
  logic [NUM_FU-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                          rr_q, rr_d;

  logic [NUM_FU-1:0]             avail;
  logic [NUM_FU-1:0]             rel_eff;
  logic [NUM_FU-1:0]             granted_to;

  logic [NUM_REQ-1:0][NUM_FU-1:0] slot_avail;
  logic [NUM_REQ-1:0][NUM_FU-1:0] slot_mask;
  logic [NUM_REQ-1:0][NUM_FU-1:0] slot_taken;
  logic [NUM_REQ-1:0]             slot_order_ok;
  logic [NUM_REQ-1:0]             pick_vld;
  fu_idx_t [NUM_REQ-1:0]          pick_idx;

  // A completing unit is reusable in the same cycle; releases on idle units do nothing.
  assign avail   = ~busy_q | i_release;
  assign rel_eff = i_release & busy_q;

  // Slot chain: each younger slot sees what older slots left and only issues behind them.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign slot_avail[k]    = avail;
      assign slot_order_ok[k] = 1'b1;
    end else begin : g_next
      assign slot_avail[k]    = slot_avail[k-1] & ~slot_taken[k-1];
      assign slot_order_ok[k] = slot_order_ok[k-1] & (o_grant[k-1] | ~i_req_valid[k-1]);
    end

    assign slot_mask[k] = (fu_kind_e'(i_req_kind[k]) == FU_LSU) ? LSU_MASK : ALU_MASK;

    fu_pick #(
      .NUM_FU   (NUM_FU),
      .ALU_MASK (ALU_MASK)
    ) u_pick (
      .avail_i     (slot_avail[k]),
      .kind_mask_i (slot_mask[k]),
      .rr_ptr_i    (rr_q),
      .pick_vld_o  (pick_vld[k]),
      .pick_idx_o  (pick_idx[k])
    );

    assign o_grant[k]    = i_req_valid[k] & slot_order_ok[k] & pick_vld[k];
    assign o_grant_fu[k] = o_grant[k] ? pick_idx[k] : 2'd0;
    assign slot_taken[k] = o_grant[k] ? (NUM_FU'(1) << pick_idx[k]) : '0;
  end

  assign o_stall = |(i_req_valid & ~o_grant);

  // Collect per-slot grants into a per-FU allocation vector.
  always_comb begin
    granted_to = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      granted_to = granted_to | slot_taken[k];
    end
  end

  // Busy tracking: allocation wins over a same-cycle release; one rr toggle per cycle.
  always_comb begin
    busy_d = (busy_q & ~i_release) | granted_to;
    rr_d   = rr_q ^ (|(granted_to & ALU_MASK));
  end

  // Watchdog: count busy cycles, reload on release or new grant, flag is sticky until release.
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (granted_to[i] || rel_eff[i]) begin
        cnt_d[i] = '0;
      end else if (busy_q[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      if (rel_eff[i]) begin
        to_d[i] = 1'b0;
      end else if (busy_q[i] && (cnt_q[i] == TO_LIMIT)) begin
        to_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset discards all allocation state immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
      to_q   <= '0;
      cnt_q  <= '0;
      rr_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      to_q   <= to_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  assign o_fu_free  = ~busy_q;
  assign o_timeout  = to_q;
  assign o_busy_cnt = cnt_q;

endmodule

// File: tb/tb_fu_alloc_ctrl.sv
// Bench for fu_alloc_ctrl: directed scenarios followed by random traffic, all checked
// against a per-FU behavioural model of busy/round-robin/watchdog rules.
module tb_fu_alloc_ctrl;

  localparam int TIMEOUT = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [1:0]       i_req_valid;
  logic [1:0]       i_req_kind;
  logic [2:0]       i_release;
  logic [1:0]       o_grant;
  logic [1:0][1:0]  o_grant_fu;
  logic             o_stall;
  logic [2:0]       o_fu_free;
  logic [2:0]       o_timeout;
  logic [2:0][7:0]  o_busy_cnt;

  fu_alloc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_kind  (i_req_kind),
    .i_release   (i_release),
    .o_grant     (o_grant),
    .o_grant_fu  (o_grant_fu),
    .o_stall     (o_stall),
    .o_fu_free   (o_fu_free),
    .o_timeout   (o_timeout),
    .o_busy_cnt  (o_busy_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  bit m_busy [3];
  int m_cnt  [3];
  bit m_to   [3];
  int m_rr;

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_cnt[i]  = 0;
      m_to[i]   = 1'b0;
    end
    m_rr = 0;
  endtask

  // Called at posedge+1: drive, check at negedge, advance model, return at next posedge+1.
  task automatic step(input logic [1:0] v, input logic [1:0] k, input logic [2:0] rel);
    bit         fr  [3];
    bit         gto [3];
    logic [1:0] eg;
    logic [1:0] ef  [2];
    logic [2:0] efree;
    int         pick;
    bit         rel_eff;

    i_req_valid = v;
    i_req_kind  = k;
    i_release   = rel;

    for (int i = 0; i < 3; i++) begin
      fr[i]    = !m_busy[i] || rel[i];
      gto[i]   = 1'b0;
      efree[i] = !m_busy[i];
    end
    eg    = 2'b00;
    ef[0] = 2'd0;
    ef[1] = 2'd0;
    for (int s = 0; s < 2; s++) begin
      pick = -1;
      if (v[s] && (s == 0 || !v[0] || eg[0])) begin
        if (k[s]) begin
          if (fr[2]) pick = 2;
        end else if (fr[0] && fr[1]) begin
          pick = m_rr;
        end else if (fr[0]) begin
          pick = 0;
        end else if (fr[1]) begin
          pick = 1;
        end
      end
      if (pick >= 0) begin
        eg[s]    = 1'b1;
        ef[s]    = 2'(pick);
        fr[pick] = 1'b0;
        gto[pick] = 1'b1;
      end
    end

    #4;
    chk("grant",     o_grant,       eg);
    chk("grant_fu0", o_grant_fu[0], ef[0]);
    chk("grant_fu1", o_grant_fu[1], ef[1]);
    chk("stall",     o_stall,       |(v & ~eg));
    chk("fu_free",   o_fu_free,     efree);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("timeout%0d", i),  o_timeout[i],  m_to[i]);
      chk($sformatf("busy_cnt%0d", i), o_busy_cnt[i], m_cnt[i]);
    end

    for (int i = 0; i < 3; i++) begin
      rel_eff = rel[i] && m_busy[i];
      if (rel_eff) m_to[i] = 1'b0;
      else if (m_busy[i] && m_cnt[i] == TIMEOUT - 1) m_to[i] = 1'b1;
      if (gto[i] || rel_eff) m_cnt[i] = 0;
      else if (m_busy[i]) m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
      m_busy[i] = (m_busy[i] && !rel[i]) || gto[i];
    end
    if (gto[0] || gto[1]) m_rr = 1 - m_rr;

    @(posedge i_clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    i_rst_n     = 1'b0;
    i_req_valid = 2'b00;
    i_req_kind  = 2'b00;
    i_release   = 3'b000;
    model_reset();

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_free",    o_fu_free, 3'b111);
    chk("rst_grant",   o_grant,   2'b00);
    chk("rst_stall",   o_stall,   1'b0);
    chk("rst_timeout", o_timeout, 3'b000);
    i_rst_n = 1'b1;

    step(2'b00, 2'b00, 3'b000);
    step(2'b00, 2'b00, 3'b000);
    // Two ALU requests with both ALUs free: FU0 to slot 0, FU1 to slot 1
    step(2'b11, 2'b00, 3'b000);
    step(2'b00, 2'b00, 3'b000);
    chk("pair_free", o_fu_free, 3'b100);
    // Slot 0 ALU blocked holds back LSU slot 1
    step(2'b11, 2'b10, 3'b000);
    // Release FU1: slot 0 takes FU1, slot 1 takes FU2
    step(2'b11, 2'b10, 3'b010);
    // FU2 released and re-granted to an LSU request in the same cycle
    step(2'b01, 2'b01, 3'b100);
    // Free the ALUs and hold FU2 through timeout and saturation
    step(2'b00, 2'b00, 3'b011);
    repeat (280) step(2'b00, 2'b00, 3'b000);
    chk("sat_cnt2", o_busy_cnt[2], 8'd255);
    chk("sat_to2",  o_timeout[2],  1'b1);
    step(2'b00, 2'b00, 3'b100);
    step(2'b00, 2'b00, 3'b000);
    // Release on an idle FU is ignored
    step(2'b00, 2'b00, 3'b010);
    step(2'b00, 2'b00, 3'b000);
    // Single ALU request each cycle with prior grant released: alternates FUs
    repeat (4) step(2'b01, 2'b00, 3'b011);
    step(2'b00, 2'b00, 3'b011);

    // Asynchronous reset with an ALU busy
    step(2'b01, 2'b00, 3'b000);
    i_req_valid = 2'b00;
    i_release   = 3'b000;
    i_rst_n     = 1'b0;
    #1;
    chk("async_rst_free", o_fu_free, 3'b111);
    chk("async_rst_cnt0", o_busy_cnt[0], 8'd0);
    chk("async_rst_cnt1", o_busy_cnt[1], 8'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(2'b00, 2'b00, 3'b000);

    // Random traffic with sparse releases so units stay busy for a while
    for (int n = 0; n < 600; n++) begin
      logic [2:0] rel;
      rel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      step(2'($urandom), 2'($urandom), rel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_alloc_ctrl.md
Name: fu_alloc_ctrl

Overview:
- Scheduler for the three issue functional units (FU0, FU1 = ALU; FU2 = LSU), shared between the two dispatch slots.
- Tracks a busy bit per FU and grants dispatch requests in program order.
- Frees an FU when it reports completion, with a round-robin pointer that balances the two ALUs.
- Replaces the ad-hoc OR of dispatch and complete free flags in the top level.
- Adds a per-FU watchdog that flags a unit held busy too long.

Parameters:
NUM_FU, 3, number of functional units
NUM_REQ, 2, dispatch slots per cycle
ALU_MASK, 3'b011, bit i set means FU i executes ALU ops
LSU_MASK, 3'b100, bit i set means FU i executes load/store ops
TIMEOUT, 16, busy cycles before the watchdog flag sets (range 2..255)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  [NUM_REQ]  slot k requests an FU this cycle
i_req_kind  in  [NUM_REQ] x 1  0 = ALU, 1 = LSU
i_release  in  [NUM_FU]  FU i completed this cycle and returns to free
o_grant  out  [NUM_REQ]  slot k granted this cycle (combinational)
o_grant_fu  out  [NUM_REQ] x 2  index of the FU granted to slot k
o_stall  out  1  some valid slot was not granted
o_fu_free  out  [NUM_FU]  registered free bits
o_timeout  out  [NUM_FU]  sticky watchdog flag per FU
o_busy_cnt  out  [NUM_FU] x 8  cycles FU i has been busy (debug)

Behaviour:
- Reset (async, active-low): busy=0, so o_fu_free=3'b111. rr_ptr=0. Counters=0. o_timeout=0. Grant outputs reflect the reset state: no grant without a request.
- Availability in cycle t: avail[i] = ~busy[i] | i_release[i]. A release bypasses into the same cycle's allocation.
- Slot 0 candidates: avail & kind mask.
  - ALU, both FUs available: pick FU rr_ptr.
  - Otherwise: pick the lowest available index.
- Slot 1: same rule, with slot 0's pick removed from avail.
  - When both slots are ALU and both ALUs are available: slot 0 gets FU rr_ptr, slot 1 gets the other.
- In-order rule: slot 1 is granted only if slot 0 is granted or ~i_req_valid[0]. No slot-1 bypass of a stalled slot 0.
- o_grant_fu is 0 when the slot is not granted.
- o_stall = |(i_req_valid & ~o_grant).
- Combinational latency: grant outputs depend combinationally on i_req_* and i_release.
- Posedge update, busy_next[i] = (busy[i] & ~i_release[i]) | granted_to[i]. Allocation wins over release on the same FU, so release and regrant in the same cycle keeps it busy.
- rr_ptr toggles on each cycle with at least one ALU grant. The toggle is counted once per cycle, so two ALU grants in one cycle cause one toggle.
- Counter update:
  - Busy FU: counter +1, saturating at 255.
  - FU with release or newly granted: counter reloads to 0.
- o_timeout[i] sets when the counter reaches TIMEOUT-1 while busy. It clears only on i_release[i] or reset.
- i_release on an already-free FU is ignored; no state change.
- Reset asserted mid-operation: all busy state discarded immediately. Any grants in flight are lost; upstream must re-dispatch.
- i_req_kind of an invalid slot is ignored.

Decomposition:
- Shared package:
  - fu_kind_e enum (FU_ALU=0, FU_LSU=1).
  - fu_idx_t (2-bit).
  - FU count and mask constants, so DISPATCH/ISSUE use the same encoding.
- One sub-module, fu_pick: purely combinational priority/round-robin picker (avail, kind mask, rr_ptr → valid, idx). It is instantiated twice, chained for slot 1.
- Watchdog counters stay inline.

Test Plan:
- Reset, then idle → o_fu_free=111, o_grant=00, o_stall=0. Assert i_rst_n=0 mid-run with FU0 busy → o_fu_free returns to 111 without waiting for a clock.
- Slot0 ALU + slot1 ALU, rr_ptr=0 → slot0 granted FU0 and slot1 granted FU1. Next cycle o_fu_free=100 and rr_ptr=1.
- FU0, FU1 busy; slot0 ALU, slot1 LSU → o_grant=00 and o_stall=1 (in-order block). Then i_release[1]=1 → slot0 gets FU1 and slot1 gets FU2 in the same cycle.
- FU2 busy with i_release[2]=1 and slot0 LSU in the same cycle → grant FU2, FU2 stays busy, counter reloads to 0.
- Hold FU2 busy, no release, TIMEOUT=16 → o_timeout[2] rises after 16 busy cycles and stays high until i_release[2]. The counter saturates at 255 if held.
- Release on a free FU1 → no change to o_fu_free or counters. Alternating single ALU requests with immediate release → grants alternate FU0, FU1, FU0.
